// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the trace emitter: beat layout, FIFO entry and FSM states.
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int TRACE_BEAT_WIDTH         = 128;
  localparam logic [31:0] FLUSH_MARKER_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0] skip_cnt;
    logic [31:0] instr;
    logic [63:0] pc;
  } trace_beat_t;

  typedef struct packed {
    logic        last;
    trace_beat_t beat;
  } fifo_entry_t;

  typedef enum logic {
    IDLE,
    FLUSH_PEND
  } emitter_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push on a full FIFO succeeds when a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid   = !empty;
  // Head is gated so the stream data reads zero whenever nothing is buffered.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/trace_emitter.sv
// Packs kept trace items into 128-bit stream beats with skip counts, packet limits and flush markers.
// state      | meaning
// IDLE       | normal capture; flush markers enqueued immediately when there is room
// FLUSH_PEND | a flush marker is owed but the FIFO was full; kept items are lost until it is written
module trace_emitter
  import continuous_monitoring_system_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int PACKET_ITEMS = 32,
  parameter int SKIP_WIDTH   = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                item_valid,
  input  logic [63:0]                         item_pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] item_instr,
  input  logic                                drop_instr,
  input  logic                                flush,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [TRACE_BEAT_WIDTH-1:0]         m_tdata,
  output logic                                m_tlast,
  output logic                                overflow,
  output logic [31:0]                         lost_cnt
);

  localparam logic [15:0] PKT_LAST = 16'(PACKET_ITEMS - 1);

  emitter_state_t          state, state_nxt;
  logic [SKIP_WIDTH-1:0]   skip_cnt, skip_nxt, skip_plus;
  logic [15:0]             pkt_cnt, pkt_nxt;
  logic [31:0]             lost_nxt;
  logic                    ovf_nxt;
  logic                    accept, kept, flush_eff, pop, fifo_ok, fifo_full, item_last;
  logic                    push;
  fifo_entry_t             push_entry, head;

  assign accept    = en && item_valid;
  assign kept      = accept && !drop_instr;
  assign flush_eff = en && flush;
  assign pop       = m_tvalid && m_tready;
  assign fifo_ok   = !fifo_full || pop;
  assign skip_plus = (skip_cnt == '1) ? skip_cnt : skip_cnt + 1'b1;
  assign item_last = (pkt_cnt == PKT_LAST) || flush_eff;

  always_comb begin
    state_nxt  = state;
    skip_nxt   = skip_cnt;
    pkt_nxt    = pkt_cnt;
    lost_nxt   = lost_cnt;
    ovf_nxt    = overflow;
    push       = 1'b0;
    push_entry = '0;
    case (state)
      IDLE: begin
        if (kept && fifo_ok) begin
          push       = 1'b1;
          push_entry = '{last: item_last,
                         beat: '{skip_cnt: 32'(skip_cnt), instr: item_instr, pc: item_pc}};
          skip_nxt   = '0;
          pkt_nxt    = item_last ? 16'd0 : pkt_cnt + 16'd1;
        end else begin
          // A lost kept item also bumps skip so the gap shows up in the next beat.
          if (accept) skip_nxt = skip_plus;
          if (kept) begin
            lost_nxt = sat_inc32(lost_cnt);
            ovf_nxt  = 1'b1;
          end
          if (flush_eff && (pkt_cnt != 16'd0 || skip_nxt != '0)) begin
            if (fifo_ok) begin
              push       = 1'b1;
              push_entry = '{last: 1'b1,
                             beat: '{skip_cnt: 32'(skip_nxt), instr: FLUSH_MARKER_INSTR, pc: 64'h0}};
              skip_nxt   = '0;
              pkt_nxt    = 16'd0;
            end else begin
              state_nxt = FLUSH_PEND;
            end
          end
        end
      end
      FLUSH_PEND: begin
        if (accept) skip_nxt = skip_plus;
        if (kept) begin
          lost_nxt = sat_inc32(lost_cnt);
          ovf_nxt  = 1'b1;
        end
        if (fifo_ok) begin
          push       = 1'b1;
          push_entry = '{last: 1'b1,
                         beat: '{skip_cnt: 32'(skip_nxt), instr: FLUSH_MARKER_INSTR, pc: 64'h0}};
          skip_nxt   = '0;
          pkt_nxt    = 16'd0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
      pkt_cnt  <= '0;
      lost_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      pkt_cnt  <= pkt_nxt;
      lost_cnt <= lost_nxt;
      overflow <= ovf_nxt;
    end
  end

  trace_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .valid (m_tvalid),
    .full  (fifo_full)
  );

  assign m_tdata = head.beat;
  assign m_tlast = head.last;

endmodule

// File: tb/tb_trace_emitter.sv
// Directed bench for trace_emitter with PACKET_ITEMS=4 and a 16-entry FIFO.
module tb_trace_emitter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         item_valid = 1'b0;
  logic [63:0]  item_pc = '0;
  logic [31:0]  item_instr = '0;
  logic         drop_instr = 1'b0;
  logic         flush = 1'b0;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [127:0] m_tdata;
  logic         m_tlast;
  logic         overflow;
  logic [31:0]  lost_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  trace_emitter #(
    .FIFO_DEPTH   (16),
    .PACKET_ITEMS (4),
    .SKIP_WIDTH   (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .item_valid (item_valid),
    .item_pc    (item_pc),
    .item_instr (item_instr),
    .drop_instr (drop_instr),
    .flush      (flush),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .overflow   (overflow),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] beat(input logic [31:0] skip, input logic [31:0] ins,
                                        input logic [63:0] pc);
    return {skip, ins, pc};
  endfunction

  // One cycle: present inputs, clock, then return to idle 1 time unit after the edge.
  task automatic step(input logic v, input logic drop, input logic fl,
                      input logic [63:0] pc, input logic [31:0] ins);
    item_valid = v; drop_instr = drop; flush = fl; item_pc = pc; item_instr = ins;
    @(posedge clk); #1;
    item_valid = 1'b0; drop_instr = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic keep(input logic [63:0] pc, input logic [31:0] ins);
    step(1'b1, 1'b0, 1'b0, pc, ins);
  endtask

  task automatic drop_one();
    step(1'b1, 1'b1, 1'b0, 64'h0, 32'h0000_0013);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  initial begin
    // T1: reset state and basic skip counting
    do_reset();
    chk("rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_tdata", m_tdata, 128'(0));
    chk("rst_tlast", 128'(m_tlast), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_lost", 128'(lost_cnt), 128'(0));
    m_tready = 1'b1;
    keep(64'h8000_0000, 32'h0000_006F);
    chk("t1_b0_valid", 128'(m_tvalid), 128'(1));
    chk("t1_b0_data", m_tdata, beat(32'd0, 32'h0000_006F, 64'h8000_0000));
    chk("t1_b0_last", 128'(m_tlast), 128'(0));
    drop_one();
    chk("t1_drop_novalid", 128'(m_tvalid), 128'(0));
    drop_one();
    keep(64'h8000_000C, 32'h0000_8067);
    chk("t1_b1_valid", 128'(m_tvalid), 128'(1));
    chk("t1_b1_data", m_tdata, beat(32'd2, 32'h0000_8067, 64'h8000_000C));
    idle();
    chk("t1_empty", 128'(m_tvalid), 128'(0));

    // T2: packet limit of 4 then flush marker
    do_reset();
    for (int k = 0; k < 9; k++) begin
      keep(64'h1000 + 64'(4 * k), 32'hB000_0000 + 32'(k));
      chk("t2_data", m_tdata, beat(32'd0, 32'hB000_0000 + 32'(k), 64'h1000 + 64'(4 * k)));
      chk("t2_last", 128'(m_tlast), 128'((k == 3) || (k == 7)));
    end
    step(1'b0, 1'b0, 1'b1, 64'h0, 32'h0);
    chk("t2_mark_valid", 128'(m_tvalid), 128'(1));
    chk("t2_mark_data", m_tdata, beat(32'd0, 32'h0, 64'h0));
    chk("t2_mark_last", 128'(m_tlast), 128'(1));
    idle();
    chk("t2_empty", 128'(m_tvalid), 128'(0));

    // T3: overflow while stalled, stability, ordered drain
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      keep(64'h2000 + 64'(4 * k), 32'hC000_0000 + 32'(k));
      chk("t3_stall_data", m_tdata, beat(32'd0, 32'hC000_0000, 64'h2000));
      chk("t3_stall_last", 128'(m_tlast), 128'(0));
    end
    chk("t3_lost", 128'(lost_cnt), 128'(4));
    chk("t3_ovf", 128'(overflow), 128'(1));
    m_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t3_drain_valid", 128'(m_tvalid), 128'(1));
      chk("t3_drain_data", m_tdata, beat(32'd0, 32'hC000_0000 + 32'(k), 64'h2000 + 64'(4 * k)));
      chk("t3_drain_last", 128'(m_tlast), 128'((k % 4) == 3));
      idle();
    end
    chk("t3_empty", 128'(m_tvalid), 128'(0));

    // T6: asynchronous reset with 7 beats buffered and live counters
    m_tready = 1'b0;
    for (int k = 0; k < 7; k++) keep(64'h6000 + 64'(4 * k), 32'hD000_0000 + 32'(k));
    repeat (3) drop_one();
    chk("t6_pre_valid", 128'(m_tvalid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 128'(m_tvalid), 128'(0));
    chk("t6_async_data", m_tdata, 128'(0));
    chk("t6_async_lost", 128'(lost_cnt), 128'(0));
    chk("t6_async_ovf", 128'(overflow), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    m_tready = 1'b1;
    idle();
    chk("t6_no_stale", 128'(m_tvalid), 128'(0));
    for (int k = 0; k < 4; k++) begin
      keep(64'h7000 + 64'(4 * k), 32'hE000_0000 + 32'(k));
      chk("t6_post_data", m_tdata, beat(32'd0, 32'hE000_0000 + 32'(k), 64'h7000 + 64'(4 * k)));
      chk("t6_post_last", 128'(m_tlast), 128'(k == 3));
    end
    idle();

    // T4: enqueue and dequeue in the same cycle on a full FIFO
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) keep(64'h3000 + 64'(4 * k), 32'hA000_0000 + 32'(k));
    chk("t4_full_lost", 128'(lost_cnt), 128'(0));
    m_tready = 1'b1;
    keep(64'h3000 + 64'(4 * 16), 32'hA000_0000 + 32'(16));
    m_tready = 1'b0;
    chk("t4_lost", 128'(lost_cnt), 128'(0));
    chk("t4_ovf", 128'(overflow), 128'(0));
    chk("t4_head", m_tdata, beat(32'd0, 32'hA000_0001, 64'h3004));
    m_tready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("t4_drain_data", m_tdata, beat(32'd0, 32'hA000_0000 + 32'(k), 64'h3000 + 64'(4 * k)));
      chk("t4_drain_last", 128'(m_tlast), 128'((k % 4) == 3));
      idle();
    end
    chk("t4_empty", 128'(m_tvalid), 128'(0));

    // T5: flush while full goes pending, marker lands on the first pop
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) keep(64'h4000 + 64'(4 * k), 32'hF000_0000 + 32'(k));
    repeat (5) drop_one();
    step(1'b0, 1'b0, 1'b1, 64'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 64'h0, 32'h0);
    chk("t5_lost", 128'(lost_cnt), 128'(0));
    m_tready = 1'b1;
    idle();
    m_tready = 1'b0;
    chk("t5_head", m_tdata, beat(32'd0, 32'hF000_0001, 64'h4004));
    m_tready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      chk("t5_drain_data", m_tdata, beat(32'd0, 32'hF000_0000 + 32'(k), 64'h4000 + 64'(4 * k)));
      idle();
    end
    chk("t5_mark_data", m_tdata, beat(32'd5, 32'h0, 64'h0));
    chk("t5_mark_last", 128'(m_tlast), 128'(1));
    idle();
    chk("t5_single_mark", 128'(m_tvalid), 128'(0));
    keep(64'h4800, 32'h1234_5678);
    chk("t5_idle_again", m_tdata, beat(32'd0, 32'h1234_5678, 64'h4800));
    chk("t5_idle_last", 128'(m_tlast), 128'(0));
    idle();
    en = 1'b0;
    step(1'b1, 1'b0, 1'b1, 64'h4900, 32'h1111_1111);
    chk("t5_en_off", 128'(m_tvalid), 128'(0));
    en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
